// File: rtl/minimig_sram_arbiter.sv
// minimig_sram_arbiter: shares the SRAM bridge port between the chipset DMA slot and the CPU,
// sequencing each slot on the Q0..Q3 phases decoded from c1/c3.
module minimig_sram_arbiter #(
    parameter int CPU_MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        c1,
    input  logic        c3,
    input  logic        chip_sel,
    input  logic [7:0]  chip_bank,
    input  logic [22:0] chip_addr,
    input  logic        chip_rd,
    input  logic        chip_hwr,
    input  logic        chip_lwr,
    input  logic [15:0] chip_wdata,
    output logic [15:0] chip_rdata,
    input  logic        cpu_req,
    input  logic [7:0]  cpu_bank,
    input  logic [22:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_hwr,
    input  logic        cpu_lwr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic        cpu_starved,
    output logic [7:0]  bank,
    output logic [22:0] address,
    output logic [15:0] data_out,
    output logic        rd,
    output logic        hwr,
    output logic        lwr,
    input  logic [15:0] data_in
);
    typedef enum logic [1:0] {IDLE, CHIP, CPU} state_t;
    state_t      state;
    logic [1:0]  step;
    logic [7:0]  starve_cnt;
    logic        want_h, want_l;
    logic        q0, q3;
    assign q0 = !c1 && !c3;
    assign q3 = !c1 && c3;
    assign cpu_starved = starve_cnt >= 8'(CPU_MAX_WAIT);
    // Every Q0 re-arbitrates, so a Q0 seen mid-slot simply replaces the aborted slot.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state      <= IDLE;
            step       <= 2'd0;
            starve_cnt <= 8'd0;
            want_h     <= 1'b0;
            want_l     <= 1'b0;
            bank       <= 8'd0;
            address    <= 23'd0;
            data_out   <= 16'd0;
            rd         <= 1'b0;
            hwr        <= 1'b0;
            lwr        <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= 16'd0;
            chip_rdata <= 16'd0;
        end else begin
            cpu_ack <= 1'b0;
            if (q0) begin
                step       <= 2'd0;
                hwr        <= 1'b0;
                lwr        <= 1'b0;
                starve_cnt <= chip_sel && cpu_req ? (&starve_cnt ? starve_cnt : starve_cnt + 8'd1) : 8'd0;
                if (chip_sel) begin
                    state    <= CHIP;
                    bank     <= chip_bank;
                    address  <= chip_addr;
                    data_out <= chip_wdata;
                    rd       <= chip_rd;
                    want_h   <= chip_hwr && !chip_rd;
                    want_l   <= chip_lwr && !chip_rd;
                end else if (cpu_req) begin
                    state    <= CPU;
                    bank     <= cpu_bank;
                    address  <= cpu_addr;
                    data_out <= cpu_wdata;
                    rd       <= cpu_rd;
                    want_h   <= cpu_hwr && !cpu_rd;
                    want_l   <= cpu_lwr && !cpu_rd;
                end else begin
                    state  <= IDLE;
                    bank   <= 8'd0;
                    rd     <= 1'b0;
                    want_h <= 1'b0;
                    want_l <= 1'b0;
                end
            end else begin
                step <= step == 2'd3 ? step : step + 2'd1;
                hwr  <= step == 2'd0 && want_h;
                lwr  <= step == 2'd0 && want_l;
                if (q3 && state == CHIP)
                    chip_rdata <= data_in;
                if (q3 && state == CPU) begin
                    cpu_rdata <= data_in;
                    cpu_ack   <= 1'b1;
                end
            end
        end
    end
endmodule
